dcmac_link_bringup: RTL and testbench

- GT/DCMAC link bring-up and recovery sequencer, directly upstream of the DCMAC helper's user GT reset inputs.
- Drives `user_gt_reset_all` and `user_gt_reset_rx_datapath[1:0]`.
- Consumes the helper's `s_axi_clk`-synchronized `gt_rx_reset_done`/`gt_tx_reset_done` and the raw GT power-good.
- Sequences cold bring-up with timeout and retry, then supervises each 100GbE port and re-resets its RX datapath on loss of lock.

---
 rtl/dcmac_bringup_pkg.sv | 27 ++
 rtl/dcmac_port_rx_recover.sv | 110 +++++++++++
 rtl/dcmac_link_bringup.sv | 147 ++++++++++++++
 tb/tb_dcmac_link_bringup.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcmac_bringup_pkg.sv
// Shared state encodings and counter sizing for the DCMAC link bring-up sequencer.
package dcmac_bringup_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE      = 3'd0,
    STATE_WAIT_PWR  = 3'd1,
    STATE_RESET_ALL = 3'd2,
    STATE_WAIT_DONE = 3'd3,
    STATE_RUN       = 3'd4,
    STATE_FAIL      = 3'd5
  } top_state_t;

  typedef enum logic [1:0] {
    PORT_UP      = 2'd0,
    PORT_RX_RST  = 2'd1,
    PORT_RX_WAIT = 2'd2,
    PORT_DOWN    = 2'd3
  } port_state_t;

  // Down-counters run from N-1 to 0, so clog2 of the largest N is enough.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dcmac_port_rx_recover.sv
// Per-port RX datapath supervisor: pulses the RX reset on loss of rx_done and retries on timeout.
// Latency: outputs registered, one cycle after the input event.
// Backpressure: none; rx_done is a level, gives up into DOWN after the retry budget.
module dcmac_port_rx_recover
  import dcmac_bringup_pkg::*;
#(
  parameter int RX_RESET_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       s_axi_clk,
  input  logic       resetn,
  input  logic       active,
  input  logic       clear_retries,
  input  logic       rx_done,
  output logic       link_up,
  output logic       rx_rst,
  output logic       down,
  output logic [3:0] retry_count
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, RX_RESET_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(RX_RESET_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    MAX_EP     = 5'(MAX_RETRIES);

  port_state_t   ps_q, ps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    ep_q, ep_d;
  logic          rx_prev;
  logic          rc_inc;

  always_comb begin
    ps_d   = ps_q;
    ep_d   = ep_q;
    rc_inc = 1'b0;
    if (!active) begin
      ps_d = PORT_UP;
      ep_d = '0;
    end else begin
      case (ps_q)
        PORT_UP: begin
          if (rx_prev && !rx_done) begin
            ps_d   = PORT_RX_RST;
            ep_d   = '0;
            rc_inc = 1'b1;
          end
        end
        PORT_RX_RST: begin
          if (cnt_q == '0) ps_d = PORT_RX_WAIT;
        end
        PORT_RX_WAIT: begin
          if (rx_done) begin
            ps_d = PORT_UP;
          end else if (cnt_q == '0) begin
            // ep_q counts retries within this loss episode only
            if (ep_q <= MAX_EP) begin
              ps_d   = PORT_RX_RST;
              ep_d   = ep_q + 5'd1;
              rc_inc = 1'b1;
            end else begin
              ps_d = PORT_DOWN;
            end
          end
        end
        default: ps_d = ps_q;
      endcase
    end

    cnt_d = cnt_q;
    if (!active) begin
      cnt_d = '0;
    end else if (ps_d != ps_q) begin
      case (ps_d)
        PORT_RX_RST:  cnt_d = PULSE_LOAD;
        PORT_RX_WAIT: cnt_d = WAIT_LOAD;
        default:      cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge s_axi_clk or negedge resetn) begin
    if (!resetn) begin
      ps_q        <= PORT_UP;
      cnt_q       <= '0;
      ep_q        <= '0;
      rx_prev     <= 1'b0;
      retry_count <= '0;
      link_up     <= 1'b0;
      rx_rst      <= 1'b0;
      down        <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      ep_q    <= ep_d;
      rx_prev <= rx_done;
      if (clear_retries) begin
        retry_count <= '0;
      end else if (rc_inc && (retry_count != 4'hF)) begin
        retry_count <= retry_count + 4'd1;
      end
      link_up <= active && (ps_d == PORT_UP) && rx_done;
      rx_rst  <= active && (ps_d == PORT_RX_RST);
      down    <= active && (ps_d == PORT_DOWN);
    end
  end

endmodule

// File: rtl/dcmac_link_bringup.sv
// GT/DCMAC bring-up sequencer: power-good wait, reset_all with timeout/retry, then per-port RX supervision.
// Latency: all outputs registered; power-good loss seen within 3 cycles through the 2-FF synchronizer.
// Backpressure: none; enable=0 overrides everything and parks the GTs in reset.
module dcmac_link_bringup
  import dcmac_bringup_pkg::*;
#(
  parameter int RESET_ALL_CYCLES = 100,
  parameter int RX_RESET_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       s_axi_clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       gtpowergood,
  input  logic [1:0] gt_rx_reset_done,
  input  logic [1:0] gt_tx_reset_done,
  output logic       user_gt_reset_all,
  output logic [1:0] user_gt_reset_rx_datapath,
  output logic [1:0] link_up,
  output logic [2:0] state,
  output logic [7:0] retry_count,
  output logic [2:0] error
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, RESET_ALL_CYCLES);
  localparam logic [CW-1:0] RA_LOAD   = CW'(RESET_ALL_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_ATT   = 4'(MAX_RETRIES);

  top_state_t    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    attempts_q, attempts_d;
  logic          pg_meta, pg_sync;
  logic [1:0]    tx_prev;
  logic [1:0]    port_down;
  logic          err_global;
  logic          all_done, tx_fall, retry_ok;
  logic          run_d, idle_d;

  always_comb begin
    all_done   = (&gt_tx_reset_done) && (&gt_rx_reset_done);
    tx_fall    = |(tx_prev & ~gt_tx_reset_done);
    retry_ok   = (attempts_q < MAX_ATT);
    st_d       = st_q;
    attempts_d = attempts_q;

    if (!enable) begin
      st_d = STATE_IDLE;
    end else if (!pg_sync && (st_q == STATE_RESET_ALL || st_q == STATE_WAIT_DONE ||
                              st_q == STATE_RUN)) begin
      st_d = STATE_WAIT_PWR;
    end else begin
      case (st_q)
        STATE_IDLE:      st_d = STATE_WAIT_PWR;
        STATE_WAIT_PWR:  if (pg_sync) st_d = STATE_RESET_ALL;
        STATE_RESET_ALL: if (cnt_q == '0) st_d = STATE_WAIT_DONE;
        STATE_WAIT_DONE: begin
          // done is checked first so it wins over a coincident timeout
          if (all_done) begin
            st_d = STATE_RUN;
          end else if (cnt_q == '0) begin
            if (retry_ok) begin
              attempts_d = attempts_q + 4'd1;
              st_d       = STATE_RESET_ALL;
            end else begin
              st_d = STATE_FAIL;
            end
          end
        end
        STATE_RUN: begin
          if (tx_fall) begin
            if (retry_ok) begin
              attempts_d = attempts_q + 4'd1;
              st_d       = STATE_RESET_ALL;
            end else begin
              st_d = STATE_FAIL;
            end
          end
        end
        STATE_FAIL: st_d = STATE_FAIL;
        default:    st_d = STATE_IDLE;
      endcase
    end

    if (st_d == STATE_IDLE) attempts_d = '0;

    // One counter serves both the reset_all width and the reset_done timeout.
    cnt_d = cnt_q;
    if (st_d != st_q) begin
      case (st_d)
        STATE_RESET_ALL: cnt_d = RA_LOAD;
        STATE_WAIT_DONE: cnt_d = WAIT_LOAD;
        default:         cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign run_d  = (st_d == STATE_RUN);
  assign idle_d = (st_d == STATE_IDLE);

  always_ff @(posedge s_axi_clk or negedge resetn) begin
    if (!resetn) begin
      st_q              <= STATE_IDLE;
      cnt_q             <= '0;
      attempts_q        <= '0;
      pg_meta           <= 1'b0;
      pg_sync           <= 1'b0;
      tx_prev           <= 2'b00;
      user_gt_reset_all <= 1'b1;
      err_global        <= 1'b0;
    end else begin
      st_q              <= st_d;
      cnt_q             <= cnt_d;
      attempts_q        <= attempts_d;
      pg_meta           <= gtpowergood;
      pg_sync           <= pg_meta;
      tx_prev           <= gt_tx_reset_done;
      user_gt_reset_all <= !(st_d == STATE_WAIT_DONE || st_d == STATE_RUN);
      err_global        <= (st_d == STATE_FAIL);
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    dcmac_port_rx_recover #(
      .RX_RESET_CYCLES(RX_RESET_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
    ) u_rx_recover (
      .s_axi_clk    (s_axi_clk),
      .resetn       (resetn),
      .active       (run_d),
      .clear_retries(idle_d),
      .rx_done      (gt_rx_reset_done[p]),
      .link_up      (link_up[p]),
      .rx_rst       (user_gt_reset_rx_datapath[p]),
      .down         (port_down[p]),
      .retry_count  (retry_count[4*p +: 4])
    );
  end

  assign state = st_q;
  assign error = {port_down, err_global};

endmodule

// File: tb/tb_dcmac_link_bringup.sv
// Scenario bench for dcmac_link_bringup with randomized timing and ports; expectations from sequencing rules.
module tb_dcmac_link_bringup;

  localparam int RA = 8;
  localparam int RX = 4;
  localparam int TO = 50;
  localparam int MR = 2;

  logic       s_axi_clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       gtpowergood;
  logic [1:0] rx_done;
  logic [1:0] tx_done;
  logic       reset_all;
  logic [1:0] rx_dp;
  logic [1:0] link_up;
  logic [2:0] state;
  logic [7:0] retry_count;
  logic [2:0] error;

  dcmac_link_bringup #(
    .RESET_ALL_CYCLES(RA),
    .RX_RESET_CYCLES (RX),
    .TIMEOUT_CYCLES  (TO),
    .MAX_RETRIES     (MR)
  ) dut (
    .s_axi_clk                (s_axi_clk),
    .resetn                   (resetn),
    .enable                   (enable),
    .gtpowergood              (gtpowergood),
    .gt_rx_reset_done         (rx_done),
    .gt_tx_reset_done         (tx_done),
    .user_gt_reset_all        (reset_all),
    .user_gt_reset_rx_datapath(rx_dp),
    .link_up                  (link_up),
    .state                    (state),
    .retry_count              (retry_count),
    .error                    (error)
  );

  always #5 s_axi_clk = ~s_axi_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rc[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge s_axi_clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic run_len(input logic [2:0] s, input logic ra_exp, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (state === s && n < 2000) begin
      n++;
      if (reset_all !== ra_exp) bad++;
      step();
    end
  endtask

  function automatic logic [7:0] rc_exp();
    logic [3:0] a, b;
    a = 4'(rc[0]);
    b = 4'(rc[1]);
    return {b, a};
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_reset_all"}, 32'(reset_all), 32'd1);
    chk({pfx, "_rx_dp"},     32'(rx_dp),     32'd0);
    chk({pfx, "_link_up"},   32'(link_up),   32'd0);
    chk({pfx, "_state"},     32'(state),     32'd0);
    chk({pfx, "_retry"},     32'(retry_count), 32'd0);
    chk({pfx, "_error"},     32'(error),     32'd0);
  endtask

  // d = cycles spent in WAIT_DONE before the done lines are raised
  task automatic bring_up(input int d);
    int n, bad;
    wait_state(3'd2, 20, "enter_reset_all");
    run_len(3'd2, 1'b1, n, bad);
    chk("reset_all_len", n, RA);
    chk("reset_all_high", bad, 0);
    chk("wait_done_state", 32'(state), 32'd3);
    chk("reset_all_released", 32'(reset_all), 32'd0);
    repeat (d) step();
    rx_done = 2'b11;
    tx_done = 2'b11;
    step();
    chk("run_state", 32'(state), 32'd4);
    chk("link_up_all", 32'(link_up), 32'd3);
    chk("reset_all_in_run", 32'(reset_all), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p, q, n, w, bad, r, pulses;
    logic prev;
    logic [1:0] pbit;

    resetn      = 1'b0;
    enable      = 1'b0;
    gtpowergood = 1'b0;
    rx_done     = 2'b00;
    tx_done     = 2'b00;
    rc[0] = 0;
    rc[1] = 0;
    repeat (3) step();
    check_reset_values("por");
    resetn = 1'b1;
    step();

    // cold bring-up, random done delay inside the timeout window
    enable      = 1'b1;
    gtpowergood = 1'b1;
    bring_up(int'($urandom_range(1, TO - 1)));
    chk("run_error", 32'(error), 32'd0);

    // single-port RX recovery on a random port
    p    = int'($urandom_range(0, 1));
    q    = 1 - p;
    pbit = 2'b01 << p;
    rx_done[p] = 1'b0;
    n = 0;
    while (rx_dp[p] !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    w   = 0;
    bad = 0;
    while (rx_dp[p] === 1'b1 && w < 20) begin
      w++;
      if (link_up !== (2'b11 & ~pbit)) bad++;
      if (rx_dp[q] !== 1'b0) bad++;
      step();
    end
    rc[p] = sat15(rc[p] + 1);
    chk("rx_pulse_len", w, RX);
    chk("rx_pulse_isolation", bad, 0);
    r = int'($urandom_range(1, 40));
    repeat (r) step();
    rx_done[p] = 1'b1;
    step();
    chk("recover_link_up", 32'(link_up), 32'd3);
    chk("recover_retry", 32'(retry_count), 32'(rc_exp()));
    chk("recover_state", 32'(state), 32'd4);
    chk("recover_error", 32'(error), 32'd0);

    // the other port loses rx_done for good
    rx_done[q] = 1'b0;
    pulses = 0;
    prev   = 1'b0;
    bad    = 0;
    for (int i = 0; i < (MR + 2) * (RX + TO) + 40; i++) begin
      step();
      if (rx_dp[q] === 1'b1 && !prev) pulses++;
      prev = rx_dp[q];
      if (state !== 3'd4) bad++;
    end
    rc[q] = sat15(rc[q] + MR + 2);
    chk("down_pulses", pulses, MR + 2);
    chk("down_state_hold", bad, 0);
    chk("down_error", 32'(error), 32'(3'b010 << q));
    chk("down_link_up", 32'(link_up), 32'(pbit));
    chk("down_rx_dp", 32'(rx_dp), 32'd0);
    chk("down_retry", 32'(retry_count), 32'(rc_exp()));

    // power loss, then restore together with enable=0
    gtpowergood = 1'b0;
    wait_state(3'd1, 3, "pwr_loss_state");
    chk("pwr_loss_reset_all", 32'(reset_all), 32'd1);
    chk("pwr_loss_link_up", 32'(link_up), 32'd0);
    chk("pwr_loss_error", 32'(error), 32'd0);
    gtpowergood = 1'b1;
    enable      = 1'b0;
    step();
    chk("restore_idle_wins", 32'(state), 32'd0);
    chk("idle_reset_all", 32'(reset_all), 32'd1);
    step();
    rc[0] = 0;
    rc[1] = 0;
    chk("idle_retry_clear", 32'(retry_count), 32'(rc_exp()));

    // done lines never rise: MR+1 attempts then FAIL
    rx_done = 2'b00;
    tx_done = 2'b00;
    enable  = 1'b1;
    for (int a = 0; a <= MR; a++) begin
      wait_state(3'd2, 10, "attempt_reset_all");
      run_len(3'd2, 1'b1, n, bad);
      chk("attempt_ra_len", n, RA);
      chk("attempt_ra_high", bad, 0);
      run_len(3'd3, 1'b0, n, bad);
      chk("attempt_wait_len", n, TO);
      chk("attempt_wait_low", bad, 0);
    end
    chk("fail_state", 32'(state), 32'd5);
    chk("fail_error", 32'(error), 32'd1);
    chk("fail_reset_all", 32'(reset_all), 32'd1);
    repeat (5) step();
    chk("fail_sticky", 32'(state), 32'd5);
    enable = 1'b0;
    step();
    chk("fail_exit_state", 32'(state), 32'd0);
    chk("fail_exit_error", 32'(error), 32'd0);

    // done arriving on the last timeout cycle must win
    enable = 1'b1;
    bring_up(TO - 1);

    // asynchronous reset in the middle of an RX datapath reset
    rx_done[0] = 1'b0;
    n = 0;
    while (rx_dp[0] !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    step();
    chk("pre_arst_rx_dp", 32'(rx_dp), 32'd1);
    chk("pre_arst_retry", 32'(retry_count), 32'h01);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
